players_commands_conditioner: RTL
=================================

Name: players_commands_conditioner

Overview:
- Input-conditioning stage directly upstream of the game domain logic.
- Takes the four raw player push-button pins (red, blue, green, yellow), synchronises each to clk, debounces it, and drives clean level signals onto the players_commands_* inputs of the domain logic.
- Also produces one-cycle press pulses and an aggregate press strobe for activity/attract logic.

Parameters:
- DEBOUNCE_CLK_COUNT, 500000, number of consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); must be >= 1.
- BTN_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed, 0 = raw pin reads 1 when pressed.
- STUCK_CLK_COUNT, 500000000, hold duration (clk cycles) after which a pressed button is declared stuck; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn_raw_red  input  1  raw red button pin, asynchronous to clk.
- btn_raw_blue  input  1  raw blue button pin.
- btn_raw_green  input  1  raw green button pin.
- btn_raw_yellow  input  1  raw yellow button pin.
- players_commands_red  output  1  debounced level, 1 = pressed.
- players_commands_blue  output  1  debounced level.
- players_commands_green  output  1  debounced level.
- players_commands_yellow  output  1  debounced level.
- press_pulse  output  4  one-cycle pulse per accepted press; bit0 red, bit1 blue, bit2 green, bit3 yellow.
- any_press  output  1  OR of press_pulse bits, same cycle.
- stuck  output  4  per-channel stuck flag; same bit order as press_pulse.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Synchroniser flops load the "released" raw level, so no false press appears after reset.
  - All counters clear to 0; every channel FSM enters RELEASED.
  - All outputs are 0.
- Synchroniser: two-flop chain per channel. Its output is normalised by BTN_ACTIVE_LOW so that sync = 1 means pressed. No other logic may sample the raw pins.
- Per-channel FSM; the four channels are identical and fully independent. Simultaneous presses on any combination of channels are handled in parallel, with no arbitration.
  - RELEASED: cmd = 0. If sync = 1, go to PRESS_WAIT and clear cnt.
  - PRESS_WAIT: cmd = 0.
    - If sync = 0, return to RELEASED (glitch rejected).
    - Else if cnt == DEBOUNCE_CLK_COUNT-1, go to PRESSED and pulse press_pulse for 1 cycle.
    - Else cnt++.
  - PRESSED: cmd = 1. If sync = 0, go to RELEASE_WAIT and clear cnt.
  - RELEASE_WAIT: cmd = 1.
    - If sync = 1, return to PRESSED with no new pulse.
    - Else if cnt == DEBOUNCE_CLK_COUNT-1, go to RELEASED.
    - Else cnt++.
- Timing and widths:
  - Latency: with edge 0 being the first clk edge at which the synchroniser samples a stable pressed level, cmd and press_pulse become 1 after edge DEBOUNCE_CLK_COUNT+2. Release uses the same latency.
  - Any raw pulse shorter than DEBOUNCE_CLK_COUNT cycles (after synchronisation) produces no output change.
  - cnt width is $clog2(DEBOUNCE_CLK_COUNT+1). cnt never wraps; it saturates by construction through the FSM exit.
  - All outputs are registered, with no combinational path from the raw pins.
- press_pulse:
  - Exactly one pulse per accepted press.
  - A bounce during release that returns to PRESSED must not re-pulse.
  - Holding the button produces no repeat pulses.
- Reset mid-operation: any state returns to RELEASED immediately. A button held through reset release is re-qualified from scratch: a full debounce, then a fresh pulse.

Optional Feature:
- Macro: PLAYER_CMD_STUCK_DETECT_EN.
- With the macro defined:
  - Each channel has a hold counter of width $clog2(STUCK_CLK_COUNT+1), cleared on entry to PRESSED.
  - The hold counter increments in PRESSED and RELEASE_WAIT and resets on return to PRESSED from RELEASE_WAIT.
  - When it reaches STUCK_CLK_COUNT-1, the channel enters STUCK: cmd = 0 and stuck bit = 1.
  - STUCK exits to RELEASED only after sync = 0 for DEBOUNCE_CLK_COUNT consecutive cycles, with no press pulse. The stuck bit clears on that exit.
- Without the macro: no STUCK state and no hold counter; the stuck output is tied to 4'b0000.

Test Plan:
- DEBOUNCE_CLK_COUNT=4, BTN_ACTIVE_LOW=1; drive btn_raw_red 1->0 and hold -> players_commands_red=1 and press_pulse=4'b0001 for exactly one cycle after edge 6; any_press=1 in that same cycle.
- Red raw low for 3 cycles then high -> players_commands_red stays 0 and press_pulse stays 0 throughout.
- Red held pressed, then raw release bounces (high 2 cycles, low 1, high) -> cmd stays 1 through the bounce, drops 6 edges after the final stable-high sample, no second pulse.
- Press all four buttons on the same edge -> all four cmd outputs rise on the same cycle; press_pulse=4'b1111 for one cycle.
- Hold blue pressed, assert reset=0 for 2 cycles mid-hold, release reset -> all outputs 0 during reset; blue re-debounces and pulses press_pulse=4'b0010 six edges after reset deassertion (first sample edge counted as 0).
- With PLAYER_CMD_STUCK_DETECT_EN, STUCK_CLK_COUNT=20: hold green -> cmd=1, then 20 cycles later cmd=0 and stuck=4'b0100; release for 4 stable cycles -> stuck=0, no press_pulse.

Source files
------------

// File: rtl/players_commands_conditioner.sv
// Player push-button conditioner: 2-flop sync, per-channel debounce FSM, registered levels/pulses.
// Define PLAYER_CMD_STUCK_DETECT_EN to add per-channel stuck-button detection.
module players_commands_conditioner #(
  parameter int DEBOUNCE_CLK_COUNT = 500000,
  parameter bit BTN_ACTIVE_LOW     = 1'b1,
  parameter int STUCK_CLK_COUNT    = 500000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw_red,
  input  logic       btn_raw_blue,
  input  logic       btn_raw_green,
  input  logic       btn_raw_yellow,
  output logic       players_commands_red,
  output logic       players_commands_blue,
  output logic       players_commands_green,
  output logic       players_commands_yellow,
  output logic [3:0] press_pulse,
  output logic       any_press,
  output logic [3:0] stuck
);

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT,
    STUCK
  } btn_state_e;

  localparam int CNT_W = $clog2(DEBOUNCE_CLK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLK_COUNT - 1);
`ifdef PLAYER_CMD_STUCK_DETECT_EN
  localparam int HOLD_W = $clog2(STUCK_CLK_COUNT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(STUCK_CLK_COUNT - 1);
`endif

  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] pressed;
  logic [3:0] cmd_d, pulse_d;
  logic [3:0] cmd_q, pulse_q;
  logic       any_press_q;

  assign raw = {btn_raw_yellow, btn_raw_green, btn_raw_blue, btn_raw_red};

  // Synchronisers reset to the released pin level so no press appears out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= {4{BTN_ACTIVE_LOW}};
      sync2_q <= {4{BTN_ACTIVE_LOW}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ {4{BTN_ACTIVE_LOW}};

`ifdef PLAYER_CMD_STUCK_DETECT_EN
  logic [3:0] stuck_d;
  logic [3:0] stuck_q;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_chan
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
        hold_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
        hold_q  <= hold_d;
`endif
      end
    end

    // The FSM exit at CNT_LAST keeps cnt from ever wrapping.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
      hold_d  = hold_q;
`endif
      case (state_q)
        RELEASED: begin
          if (pressed[g]) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed[g]) begin
            state_d = RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
            hold_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
`ifdef PLAYER_CMD_STUCK_DETECT_EN
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_d = STUCK;
            cnt_d   = '0;
          end else
`endif
          if (!pressed[g]) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
`ifdef PLAYER_CMD_STUCK_DETECT_EN
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_d = STUCK;
            cnt_d   = '0;
          end else
`endif
          if (pressed[g]) begin
            state_d = PRESSED;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
            hold_d  = '0;
`endif
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef PLAYER_CMD_STUCK_DETECT_EN
        // Leaving STUCK needs an unbroken run of released samples.
        STUCK: begin
          if (pressed[g]) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = RELEASED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_comb begin
      cmd_d[g]   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      pulse_d[g] = (state_q == PRESS_WAIT) && (state_d == PRESSED);
`ifdef PLAYER_CMD_STUCK_DETECT_EN
      stuck_d[g] = (state_d == STUCK);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q       <= '0;
      pulse_q     <= '0;
      any_press_q <= 1'b0;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
      stuck_q     <= '0;
`endif
    end else begin
      cmd_q       <= cmd_d;
      pulse_q     <= pulse_d;
      any_press_q <= |pulse_d;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
      stuck_q     <= stuck_d;
`endif
    end
  end

  assign players_commands_red    = cmd_q[0];
  assign players_commands_blue   = cmd_q[1];
  assign players_commands_green  = cmd_q[2];
  assign players_commands_yellow = cmd_q[3];
  assign press_pulse             = pulse_q;
  assign any_press               = any_press_q;
`ifdef PLAYER_CMD_STUCK_DETECT_EN
  assign stuck = stuck_q;
`else
  assign stuck = 4'b0000;
`endif

endmodule
